// File: rtl/pipe_scheduler.sv
// Pipe scheduler: scrolls three pipe pairs, keeps score and detects bird collisions.
// Build option PIPE_SCHEDULER_RANDOM_GAP_EN: LFSR-driven gap heights instead of the fixed 100/180/260 rotation.
module pipe_scheduler #(
  parameter int SCREEN_W = 640,
  parameter int SPACING  = 200,
  parameter int SPEED    = 2,
  parameter int PIPE_W   = 52,
  parameter int BIRD_X   = 250,
  parameter int BIRD_W   = 34,
  parameter int BIRD_H   = 24,
  parameter int GAP_H    = 120,
  parameter int GAP_MIN  = 60,
  parameter int FLOOR_Y  = 440
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic       animClk,
  input  logic       start,
  input  logic [9:0] birdY,
  output logic [9:0] pipeX0,
  output logic [9:0] pipeX1,
  output logic [9:0] pipeX2,
  output logic [9:0] gapY0,
  output logic [9:0] gapY1,
  output logic [9:0] gapY2,
  output logic [2:0] pipeVisible,
  output logic [9:0] score,
  output logic [1:0] state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} st_t;

  localparam logic [9:0]  X0       = 10'(SCREEN_W - 160);
  localparam logic [9:0]  X1       = 10'(SCREEN_W - 160 + SPACING);
  localparam logic [9:0]  X2       = 10'(SCREEN_W - 160 + 2 * SPACING);
  localparam logic [9:0]  SW       = 10'(SCREEN_W);
  localparam logic [9:0]  SPD      = 10'(SPEED);
  localparam logic [9:0]  WRAP_ADD = 10'(3 * SPACING - SPEED);
  localparam logic [10:0] PW       = 11'(PIPE_W);
  localparam logic [10:0] BX       = 11'(BIRD_X);
  localparam logic [10:0] BX_R     = 11'(BIRD_X + BIRD_W);
  localparam logic [10:0] BH       = 11'(BIRD_H);
  localparam logic [10:0] GH       = 11'(GAP_H);
  localparam logic [9:0]  FY       = 10'(FLOOR_Y);
  // Fixed rotation never drops below the minimum gap the random mode allows.
  localparam logic [9:0]  GT0      = 10'((100 < GAP_MIN) ? GAP_MIN : 100);
  localparam logic [9:0]  GT1      = 10'((180 < GAP_MIN) ? GAP_MIN : 180);
  localparam logic [9:0]  GT2      = 10'((260 < GAP_MIN) ? GAP_MIN : 260);

  st_t              st;
  logic             anim_q, step_q;
  logic [2:0][9:0]  px, gy, nx;
  logic [2:0][10:0] xr, nxr;
  logic [2:0]       vis, hit, wrap, pass;
  logic [9:0]       score_q, score_nx, new_gap;
  logic [10:0]      by11, sc_sum;
  logic [1:0]       inc;
  logic             collide, move;

  assign by11 = {1'b0, birdY};

  always_comb begin
    vis = '0;
    hit = '0;
    wrap = '0;
    pass = '0;
    nx = '0;
    xr = '0;
    nxr = '0;
    for (int i = 0; i < 3; i++) begin
      xr[i]   = {1'b0, px[i]} + PW;
      vis[i]  = px[i] < SW;
      wrap[i] = px[i] < SPD;
      nx[i]   = wrap[i] ? px[i] + WRAP_ADD : px[i] - SPD;
      nxr[i]  = {1'b0, nx[i]} + PW;
      hit[i]  = vis[i] && ({1'b0, px[i]} <= BX_R) && (xr[i] >= BX) &&
                ((by11 < {1'b0, gy[i]}) || (by11 + BH > {1'b0, gy[i]} + GH));
      // A respawned pipe lands far right and can never count as passing.
      pass[i] = !wrap[i] && (xr[i] >= BX) && (nxr[i] < BX);
    end
  end

  assign collide  = (|hit) || (birdY >= FY);
  assign move     = (st == RUN) && step_q && !collide;
  assign inc      = {1'b0, pass[0]} + {1'b0, pass[1]} + {1'b0, pass[2]};
  assign sc_sum   = {1'b0, score_q} + {9'b0, inc};
  assign score_nx = (sc_sum > 11'd999) ? 10'd999 : sc_sum[9:0];

`ifdef PIPE_SCHEDULER_RANDOM_GAP_EN
  logic [9:0] lfsr;

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) lfsr <= 10'h2A5;
    else        lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
  end

  assign new_gap = 10'(GAP_MIN) + {2'b00, lfsr[7:0]};
`else
  logic [1:0] gidx;

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset)            gidx <= 2'd0;
    else if (move && |wrap) gidx <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
  end

  assign new_gap = (gidx == 2'd0) ? GT0 : (gidx == 2'd1) ? GT1 : GT2;
`endif

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      st      <= IDLE;
      anim_q  <= 1'b0;
      step_q  <= 1'b0;
      px      <= {X2, X1, X0};
      gy      <= {10'd260, 10'd180, 10'd100};
      score_q <= '0;
    end else begin
      anim_q <= animClk;
      step_q <= animClk & ~anim_q;
      case (st)
        IDLE: begin
          px      <= {X2, X1, X0};
          score_q <= '0;
          if (start) st <= RUN;
        end
        RUN: begin
          if (step_q) begin
            if (collide) begin
              st <= OVER;
            end else begin
              for (int i = 0; i < 3; i++) begin
                px[i] <= nx[i];
                if (wrap[i]) gy[i] <= new_gap;
              end
              score_q <= score_nx;
            end
          end
        end
        OVER: begin
          if (start) begin
            st      <= IDLE;
            px      <= {X2, X1, X0};
            score_q <= '0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign pipeX0      = px[0];
  assign pipeX1      = px[1];
  assign pipeX2      = px[2];
  assign gapY0       = gy[0];
  assign gapY1       = gy[1];
  assign gapY2       = gy[2];
  assign pipeVisible = (st == IDLE) ? 3'b000 : vis;
  assign score       = score_q;
  assign state       = st;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Randomized bench for pipe_scheduler against a step-level game model (default gap rotation build).
module tb_pipe_scheduler;
  logic       clk = 1'b0;
  logic       rst_n, anim, start;
  logic [9:0] birdy;
  logic [9:0] pipeX0, pipeX1, pipeX2, gapY0, gapY1, gapY2, score;
  logic [2:0] pipeVisible;
  logic [1:0] state;

  pipe_scheduler dut (
    .CLOCK(clk), .reset(rst_n), .animClk(anim), .start(start), .birdY(birdy),
    .pipeX0(pipeX0), .pipeX1(pipeX1), .pipeX2(pipeX2),
    .gapY0(gapY0), .gapY1(gapY1), .gapY2(gapY2),
    .pipeVisible(pipeVisible), .score(score), .state(state)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int mx[3];
  int mg[3];
  int mscore, mstate, gidx;
  int gtab[3] = '{100, 180, 260};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = '{480, 680, 880};
    mg = '{100, 180, 260};
    mscore = 0;
    mstate = 0;
    gidx = 0;
  endtask

  function automatic bit overlaps(input int i);
    return (mx[i] < 640) && (mx[i] <= 284) && (mx[i] + 52 >= 250);
  endfunction

  task automatic model_step(input int by);
    bit coll;
    if (mstate != 1) return;
    coll = (by >= 440);
    for (int i = 0; i < 3; i++)
      if (overlaps(i) && (by < mg[i] || by + 24 > mg[i] + 120)) coll = 1;
    if (coll) begin
      mstate = 2;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (mx[i] < 2) begin
        mx[i] = mx[i] + 598;
        mg[i] = gtab[gidx];
        gidx = (gidx + 1) % 3;
      end else begin
        if (mx[i] + 52 >= 250 && mx[i] - 2 + 52 < 250 && mscore < 999) mscore++;
        mx[i] = mx[i] - 2;
      end
    end
  endtask

  task automatic model_start();
    if (mstate == 0) mstate = 1;
    else if (mstate == 2) begin
      mstate = 0;
      mx = '{480, 680, 880};
      mscore = 0;
    end
  endtask

  task automatic check_all(input string tag);
    int v;
    v = 0;
    if (mstate != 0)
      for (int i = 0; i < 3; i++) if (mx[i] < 640) v |= (1 << i);
    check({tag, ".x0"}, pipeX0, mx[0]);
    check({tag, ".x1"}, pipeX1, mx[1]);
    check({tag, ".x2"}, pipeX2, mx[2]);
    check({tag, ".g0"}, gapY0, mg[0]);
    check({tag, ".g1"}, gapY1, mg[1]);
    check({tag, ".g2"}, gapY2, mg[2]);
    check({tag, ".score"}, score, mscore);
    check({tag, ".state"}, state, mstate);
    check({tag, ".vis"}, pipeVisible, v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_step(input string tag);
    anim = 1'b1;
    model_step(birdy);
    repeat (3) tick();
    anim = 1'b0;
    repeat (3) tick();
    check_all(tag);
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    tick();
    model_start();
    start = 1'b0;
    check_all(tag);
  endtask

  // Bird height that clears whichever pipe currently shares the bird column.
  function automatic logic [9:0] safe_bird();
    for (int i = 0; i < 3; i++)
      if (overlaps(i)) return 10'(mg[i] + $urandom_range(0, 96));
    return 10'($urandom_range(0, 439));
  endfunction

  initial begin
    bit found;
    rst_n = 1'b0;
    anim = 1'b0;
    start = 1'b0;
    birdy = 10'd150;
    model_reset();
    #12;
    check_all("reset");
    tick();
    rst_n = 1'b1;
    tick();
    check_all("post_reset");

    pulse_start("start");
    repeat (10) do_step("first10");
    check("first10.x0_460", pipeX0, 460);
    check("first10.run", state, 1);

    // Long safe run: covers both scoring crossings and the pipe0 respawn.
    for (int s = 0; s < 300; s++) begin
      birdy = safe_bird();
      do_step("safe_run");
    end
    check("safe_run.score2", score, 2);

    found = 0;
    for (int s = 0; s < 200 && !found; s++) begin
      if (overlaps(0) || overlaps(1) || overlaps(2)) found = 1;
      else begin
        birdy = safe_bird();
        do_step("seek");
      end
    end
    check("overlap_found", found, 1);
    birdy = 10'd30;
    do_step("hit_pipe");
    check("hit_pipe.over", state, 2);
    repeat (2) do_step("frozen");

    pulse_start("restart_idle");
    check("restart_idle.x0", pipeX0, 480);
    check("restart_idle.score", score, 0);
    pulse_start("rerun");
    birdy = 10'd440;
    do_step("floor");
    check("floor.over", state, 2);

    start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      model_start();
      check_all("start_held");
    end
    start = 1'b0;

    for (int s = 0; s < 150; s++) begin
      birdy = safe_bird();
      do_step("run2");
    end

    // Reset with a step strobe armed but not yet applied.
    anim = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    anim = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check_all("after_release");

    pulse_start("start3");
    for (int s = 0; s < 5; s++) begin
      birdy = safe_bird();
      do_step("run3");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipe_scheduler.md
PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

Interface
REQ-001 Parameter SCREEN_W, default 640, visible screen width in pixels.
REQ-002 Parameter SPACING, default 200, horizontal pitch between pipe pairs.
REQ-003 Parameter SPEED, default 2, pixels moved per animation step.
REQ-004 Parameters PIPE_W 52, BIRD_X 250, BIRD_W 34, BIRD_H 24, GAP_H 120, GAP_MIN 60, FLOOR_Y 440: geometry in pixels.
REQ-005 CLOCK  in  1  system clock; all logic in this single domain.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 animClk  in  1  animation clock from the VGA driver, level signal, slower than CLOCK.
REQ-008 start  in  1  start/restart request, sampled on CLOCK.
REQ-009 birdY  in  10  bird top-edge Y.
REQ-010 pipeX0, pipeX1, pipeX2  out  10 each  left-edge X of pipe pair i.
REQ-011 gapY0, gapY1, gapY2  out  10 each  top of gap of pipe pair i (drives the SKIPY inputs of the drawing controller).
REQ-012 pipeVisible  out  3  bit i high when pair i is on screen.
REQ-013 score  out  10  pipes passed, binary.
REQ-014 state  out  2  0 IDLE, 1 RUN, 2 OVER.

Function
REQ-015 Step strobe: registered rising edge of animClk, one-CLOCK pulse, one cycle of latency.
REQ-016 IDLE: pipeXi = SCREEN_W-160 + i*SPACING (480/680/880); gaps hold; score 0; start=1 -> RUN on next edge.
REQ-017 RUN, per step: every pipeXi -= SPEED; if pipeXi < SPEED, pipeXi <= pipeXi + 3*SPACING - SPEED and gapYi loads a new gap the same cycle.
REQ-018 pipeVisible[i] = (pipeXi < SCREEN_W) in RUN and OVER; all zero in IDLE.
REQ-019 Score: on a step where pipeXi+PIPE_W >= BIRD_X before and < BIRD_X after the move, score += 1; saturates at 999; at most one increment per pipe per pass.
REQ-020 Collision, evaluated on pre-move positions at each step: visible pipe with pipeXi <= BIRD_X+BIRD_W and pipeXi+PIPE_W >= BIRD_X, and (birdY < gapYi or birdY+BIRD_H > gapYi+GAP_H); or birdY >= FLOOR_Y.
REQ-021 Collision in RUN -> OVER; that step moves nothing and scores nothing (collision wins over score).
REQ-022 OVER: positions, gaps, score frozen; start=1 -> IDLE, positions reloaded, score cleared.
REQ-023 start in RUN ignored; start held high loops OVER->IDLE->RUN one transition per cycle.
REQ-024 All arithmetic 10-bit unsigned; 11-bit intermediates for X+PIPE_W compares; no wrap outside REQ-017.
REQ-025 Gap source: 10-bit LFSR, taps x^10+x^7+1, advances every CLOCK.

Reset
REQ-026 reset low: state IDLE, pipeX 480/680/880, gapY 100/180/260, score 0, pipeVisible 0, LFSR 10'h2A5, edge register 0; asynchronous assert, deassert synchronous to CLOCK.
REQ-027 Reset mid-RUN discards pending step; no output changes before the next step after release.

Configuration
REQ-028 PIPE_SCHEDULER_RANDOM_GAP_EN defined: new gap = GAP_MIN + LFSR[7:0] (60..315).
REQ-029 Macro undefined: new gap cycles table 100,180,260 through a 2-bit index advanced per respawn; LFSR not built.

Verification
REQ-030 Reset, start=1 one cycle, 10 animClk edges, birdY inside gaps -> pipeX0=460, state=1, score 0.
REQ-031 Run until pipeX0 < 2 -> next step pipeX0 = old+598, gapY0 reloads; macro-off gap sequence 100,180,260.
REQ-032 birdY=150, gaps 100 -> pipe0 left edge passes 284 -> no collision; score 1 when pipe0 right edge crosses 250.
REQ-033 birdY=30 while pipe0 overlaps bird column -> state 2 on that step, positions frozen, score unchanged.
REQ-034 birdY=440 in RUN -> OVER; start=1 -> IDLE, pipeX 480/680/880, score 0.
REQ-035 reset low mid-RUN between steps -> all outputs to REQ-026 values immediately, without a CLOCK edge.
